conv_layer_sequencer: RTL and testbench

Layer-level scheduler for the convolution engine. Walks every (output channel, input channel) pair of a layer:
- requests weight loads;
- waits for the line buffer;
- fires one window sweep per pair into the window-sweep controller;
- counts returned `pixel_rdy` strobes to find sweep completion;
- drives accumulate-first/last flags to the partial-sum buffer.

It sits between the host/layer-control logic and the window-sweep plus multiplier-adder-tree pipeline.

---
 rtl/conv_layer_sequencer_pkg.sv | 29 ++
 rtl/conv_layer_sequencer_chan_index_counter.sv | 55 +++++
 rtl/conv_layer_sequencer.sv | 132 +++++++++++++
 tb/tb_conv_layer_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the convolution layer sequencer: state encoding,
// default layer geometry and pixel-count sizing helpers.
package conv_layer_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_W   = 3'd1,
      ST_WAIT_BUF = 3'd2,
      ST_SWEEP    = 3'd3,
      ST_NEXT     = 3'd4,
      ST_DONE     = 3'd5
   } seq_state_e;

   localparam int DEF_NUM_IN_CH  = 3;
   localparam int DEF_NUM_OUT_CH = 4;
   localparam int DEF_X_POS      = 22;
   localparam int DEF_Y_POS      = 22;
   localparam int DEF_CH_BITS    = 4;

   function automatic int pix_total(input int x_pos, input int y_pos);
      return x_pos * y_pos;
   endfunction

   // Counter must be able to hold the full total, not just total-1.
   function automatic int pix_cnt_bits(input int total);
      return $clog2(total + 1);
   endfunction

endpackage

// File: rtl/conv_layer_sequencer_chan_index_counter.sv
// Nested channel index counter: in_ch inner, out_ch outer, with a flag for
// the final (out_ch, in_ch) pair of the layer.
module chan_index_counter
   import conv_layer_sequencer_pkg::*;
#(
   parameter int NUM_IN_CH  = DEF_NUM_IN_CH,
   parameter int NUM_OUT_CH = DEF_NUM_OUT_CH,
   parameter int CH_BITS    = DEF_CH_BITS
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               advance,
   output logic [CH_BITS-1:0] in_ch,
   output logic [CH_BITS-1:0] out_ch,
   output logic               last_pair
);

   localparam logic [CH_BITS-1:0] IN_LAST  = CH_BITS'(NUM_IN_CH - 1);
   localparam logic [CH_BITS-1:0] OUT_LAST = CH_BITS'(NUM_OUT_CH - 1);

   logic [CH_BITS-1:0] in_ch_q, in_ch_d;
   logic [CH_BITS-1:0] out_ch_q, out_ch_d;

   always_comb begin
      in_ch_d  = in_ch_q;
      out_ch_d = out_ch_q;
      if (clear) begin
         in_ch_d  = '0;
         out_ch_d = '0;
      end else if (advance) begin
         if (in_ch_q == IN_LAST) begin
            in_ch_d  = '0;
            out_ch_d = (out_ch_q == OUT_LAST) ? '0 : out_ch_q + CH_BITS'(1);
         end else begin
            in_ch_d = in_ch_q + CH_BITS'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_ch_q  <= '0;
         out_ch_q <= '0;
      end else begin
         in_ch_q  <= in_ch_d;
         out_ch_q <= out_ch_d;
      end
   end

   assign in_ch     = in_ch_q;
   assign out_ch    = out_ch_q;
   assign last_pair = (in_ch_q == IN_LAST) && (out_ch_q == OUT_LAST);

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer scheduler: walks every (out_ch, in_ch) pair, handshakes weights and
// line buffer, launches one window sweep per pair and counts its pixels.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | waiting for layer_start
//   LOAD_W   | wt_req high until wt_ack
//   WAIT_BUF | waiting for line buffer rows of current in_ch
//   SWEEP    | counting pixel_rdy until PIX_TOTAL reached
//   NEXT     | advance channel indices
//   DONE     | one-cycle layer_done
module conv_layer_sequencer
   import conv_layer_sequencer_pkg::*;
#(
   parameter int NUM_IN_CH  = DEF_NUM_IN_CH,
   parameter int NUM_OUT_CH = DEF_NUM_OUT_CH,
   parameter int X_POS      = DEF_X_POS,
   parameter int Y_POS      = DEF_Y_POS,
   parameter int CH_BITS    = DEF_CH_BITS
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               layer_start,
   output logic               wt_req,
   input  logic               wt_ack,
   input  logic               buf_rdy,
   output logic               sweep_start,
   input  logic               pixel_rdy,
   output logic [CH_BITS-1:0] out_ch,
   output logic [CH_BITS-1:0] in_ch,
   output logic               acc_first,
   output logic               acc_last,
   output logic               layer_busy,
   output logic               layer_done,
   output logic               err_stray
);

   localparam int PIX_TOTAL = pix_total(X_POS, Y_POS);
   localparam int PIX_BITS  = pix_cnt_bits(PIX_TOTAL);
   localparam logic [PIX_BITS-1:0] PIX_LAST   = PIX_BITS'(PIX_TOTAL - 1);
   localparam logic [CH_BITS-1:0]  IN_CH_LAST = CH_BITS'(NUM_IN_CH - 1);

   seq_state_e          state_q, state_d;
   logic [PIX_BITS-1:0] pix_cnt_q, pix_cnt_d;
   logic                sweep_start_q, sweep_start_d;
   logic                err_stray_q, err_stray_d;
   logic                start_accept;
   logic                advance;
   logic                last_pair;
   logic                in_pair;

   chan_index_counter #(
      .NUM_IN_CH  (NUM_IN_CH),
      .NUM_OUT_CH (NUM_OUT_CH),
      .CH_BITS    (CH_BITS)
   ) u_chan_index_counter (
      .clock     (clock),
      .reset     (reset),
      .clear     (start_accept),
      .advance   (advance),
      .in_ch     (in_ch),
      .out_ch    (out_ch),
      .last_pair (last_pair)
   );

   always_comb begin
      state_d       = state_q;
      pix_cnt_d     = pix_cnt_q;
      sweep_start_d = 1'b0;
      start_accept  = 1'b0;
      advance       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (layer_start) begin
               start_accept = 1'b1;
               state_d      = ST_LOAD_W;
            end
         end
         ST_LOAD_W: begin
            if (wt_ack) state_d = ST_WAIT_BUF;
         end
         ST_WAIT_BUF: begin
            if (buf_rdy) begin
               state_d       = ST_SWEEP;
               sweep_start_d = 1'b1;
               pix_cnt_d     = '0;
            end
         end
         ST_SWEEP: begin
            if (pixel_rdy) begin
               pix_cnt_d = pix_cnt_q + PIX_BITS'(1);
               if (pix_cnt_q == PIX_LAST) state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            // Advancing past the final pair wraps both indices to 0 for DONE.
            advance = 1'b1;
            state_d = last_pair ? ST_DONE : ST_LOAD_W;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      err_stray_d = start_accept ? 1'b0 : err_stray_q;
      if (pixel_rdy && (state_q != ST_SWEEP)) err_stray_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         pix_cnt_q     <= '0;
         sweep_start_q <= 1'b0;
         err_stray_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pix_cnt_q     <= pix_cnt_d;
         sweep_start_q <= sweep_start_d;
         err_stray_q   <= err_stray_d;
      end
   end

   assign in_pair     = (state_q == ST_LOAD_W) || (state_q == ST_WAIT_BUF) ||
                        (state_q == ST_SWEEP)  || (state_q == ST_NEXT);
   assign wt_req      = (state_q == ST_LOAD_W);
   assign sweep_start = sweep_start_q;
   assign acc_first   = in_pair && (in_ch == '0);
   assign acc_last    = in_pair && (in_ch == IN_CH_LAST);
   assign layer_busy  = (state_q != ST_IDLE);
   assign layer_done  = (state_q == ST_DONE);
   assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: a small-geometry instance for handshake
// scenarios and a default-geometry instance for the long gappy pixel stream.
module tb_conv_layer_sequencer;

   localparam int S_NI = 2, S_NO = 2, S_X = 4, S_Y = 4;
   localparam int S_PIX = S_X * S_Y;
   localparam int D_NI = 3, D_NO = 4;
   localparam int D_PIX = 22 * 22;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_n;

   logic       s_start, s_ack, s_buf, s_pixel;
   logic       s_wt_req, s_sweep_start, s_acc_first, s_acc_last, s_busy, s_done, s_err;
   logic [3:0] s_out_ch, s_in_ch;

   logic       d_start, d_ack, d_buf, d_pixel;
   logic       d_wt_req, d_sweep_start, d_acc_first, d_acc_last, d_busy, d_done, d_err;
   logic [3:0] d_out_ch, d_in_ch;

   wire [14:0] s_outs = {s_wt_req, s_sweep_start, s_out_ch, s_in_ch, s_acc_first,
                         s_acc_last, s_busy, s_done, s_err};
   wire [14:0] d_outs = {d_wt_req, d_sweep_start, d_out_ch, d_in_ch, d_acc_first,
                         d_acc_last, d_busy, d_done, d_err};

   conv_layer_sequencer #(
      .NUM_IN_CH(S_NI), .NUM_OUT_CH(S_NO), .X_POS(S_X), .Y_POS(S_Y), .CH_BITS(4)
   ) u_small (
      .clock(clk), .reset(rst_n), .layer_start(s_start), .wt_req(s_wt_req),
      .wt_ack(s_ack), .buf_rdy(s_buf), .sweep_start(s_sweep_start),
      .pixel_rdy(s_pixel), .out_ch(s_out_ch), .in_ch(s_in_ch),
      .acc_first(s_acc_first), .acc_last(s_acc_last), .layer_busy(s_busy),
      .layer_done(s_done), .err_stray(s_err)
   );

   conv_layer_sequencer u_dflt (
      .clock(clk), .reset(rst_n), .layer_start(d_start), .wt_req(d_wt_req),
      .wt_ack(d_ack), .buf_rdy(d_buf), .sweep_start(d_sweep_start),
      .pixel_rdy(d_pixel), .out_ch(d_out_ch), .in_ch(d_in_ch),
      .acc_first(d_acc_first), .acc_last(d_acc_last), .layer_busy(d_busy),
      .layer_done(d_done), .err_stray(d_err)
   );

   // Pulse counters sampled on the falling edge.
   int s_starts = 0, s_dones = 0, d_starts = 0, d_dones = 0;
   always @(negedge clk) begin
      if (s_sweep_start === 1'b1) s_starts = s_starts + 1;
      if (s_done === 1'b1)        s_dones  = s_dones + 1;
      if (d_sweep_start === 1'b1) d_starts = d_starts + 1;
      if (d_done === 1'b1)        d_dones  = d_dones + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic s_wait_start(output bit to);
      int n = 0;
      to = 1'b0;
      while (s_sweep_start !== 1'b1) begin
         tick();
         n++;
         if (n > 60) begin to = 1'b1; break; end
      end
   endtask

   task automatic s_wait_req(output bit to);
      int n = 0;
      to = 1'b0;
      while (s_wt_req !== 1'b1) begin
         tick();
         n++;
         if (n > 60) begin to = 1'b1; break; end
      end
   endtask

   task automatic s_wait_done(output bit to);
      int n = 0;
      to = 1'b0;
      while (s_done !== 1'b1) begin
         tick();
         n++;
         if (n > 60) begin to = 1'b1; break; end
      end
   endtask

   task automatic s_pixels(input int n, input int gap_max);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, gap_max)) tick();
         s_pixel = 1'b1;
         tick();
         s_pixel = 1'b0;
      end
   endtask

   task automatic s_pulse_start();
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      vectors++;
      if (s_outs !== 15'd0) begin miscompares++; $display("FAIL reset_small got=%h exp=0", s_outs); end
      vectors++;
      if (d_outs !== 15'd0) begin miscompares++; $display("FAIL reset_dflt got=%h exp=0", d_outs); end
      @(negedge clk) rst_n = 1'b1;
      repeat (2) tick();
      vectors++;
      if (s_outs !== 15'd0) begin miscompares++; $display("FAIL idle_after_reset got=%h exp=0", s_outs); end
   endtask

   task automatic test_basic();
      bit to;
      int prev_c = 0;
      int st0 = s_starts, dn0 = s_dones;
      s_ack = 1'b1; s_buf = 1'b1;
      s_pulse_start();
      vectors++;
      if ({s_wt_req, s_busy} !== 2'b11) begin
         miscompares++; $display("FAIL start_latency got=%b exp=11", {s_wt_req, s_busy});
      end
      for (int p = 0; p < S_NI * S_NO; p++) begin
         s_wait_start(to);
         vectors++;
         if (to !== 1'b0) begin miscompares++; $display("FAIL basic_start_timeout pair=%0d", p); end
         vectors++;
         if ({s_out_ch, s_in_ch, s_acc_first, s_acc_last} !==
             {4'(p / S_NI), 4'(p % S_NI), (p % S_NI) == 0, (p % S_NI) == S_NI - 1}) begin
            miscompares++;
            $display("FAIL basic_pair p=%0d got=%0d,%0d f%b l%b", p, s_out_ch, s_in_ch, s_acc_first, s_acc_last);
         end
         if (p > 0) begin
            vectors++;
            if (cyc - prev_c !== S_PIX + 3) begin
               miscompares++; $display("FAIL pair_overhead got=%0d exp=%0d", cyc - prev_c, S_PIX + 3);
            end
         end
         prev_c = cyc;
         s_pixels(S_PIX, 0);
      end
      s_wait_done(to);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("FAIL basic_done_timeout"); end
      tick();
      vectors++;
      if (s_busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_done got=%b exp=0", s_busy); end
      vectors++;
      if ((s_starts - st0) !== 4 || (s_dones - dn0) !== 1) begin
         miscompares++; $display("FAIL basic_counts starts=%0d dones=%0d exp 4,1", s_starts - st0, s_dones - dn0);
      end
   endtask

   task automatic test_delayed();
      bit to, req_ok, sw_ok;
      int st0 = s_starts, dn0 = s_dones;
      s_ack = 1'b0; s_buf = 1'b0;
      tick();
      s_pulse_start();
      for (int p = 0; p < S_NI * S_NO; p++) begin
         s_wait_req(to);
         vectors++;
         if (to !== 1'b0) begin miscompares++; $display("FAIL delayed_req_timeout pair=%0d", p); end
         req_ok = 1'b1;
         repeat (5) begin
            if (s_wt_req !== 1'b1) req_ok = 1'b0;
            tick();
         end
         s_ack = 1'b1;
         if (s_wt_req !== 1'b1) req_ok = 1'b0;
         tick();
         s_ack = 1'b0;
         vectors++;
         if ({req_ok, s_wt_req} !== 2'b10) begin
            miscompares++; $display("FAIL wt_req_hold got hold=%b req=%b exp 1,0", req_ok, s_wt_req);
         end
         sw_ok = 1'b1;
         repeat (3) begin
            if (s_sweep_start !== 1'b0) sw_ok = 1'b0;
            tick();
         end
         s_buf = 1'b1;
         tick();
         s_buf = 1'b0;
         vectors++;
         if ({sw_ok, s_sweep_start, s_out_ch, s_in_ch} !== {2'b11, 4'(p / S_NI), 4'(p % S_NI)}) begin
            miscompares++;
            $display("FAIL start_after_buf p=%0d got early_ok=%b ss=%b pair=%0d,%0d", p, sw_ok, s_sweep_start, s_out_ch, s_in_ch);
         end
         s_pixels(S_PIX, 2);
      end
      s_wait_done(to);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("FAIL delayed_done_timeout"); end
      tick();
      vectors++;
      if ((s_starts - st0) !== 4 || (s_dones - dn0) !== 1) begin
         miscompares++; $display("FAIL delayed_counts starts=%0d dones=%0d exp 4,1", s_starts - st0, s_dones - dn0);
      end
   endtask

   task automatic test_stray();
      bit to;
      s_ack = 1'b1; s_buf = 1'b0;
      tick();
      s_pulse_start();
      tick();
      s_pixel = 1'b1;
      tick();
      s_pixel = 1'b0;
      vectors++;
      if (s_err !== 1'b1) begin miscompares++; $display("FAIL stray_set got=%b exp=1", s_err); end
      s_buf = 1'b1;
      tick();
      s_buf = 1'b0;
      vectors++;
      if (s_sweep_start !== 1'b1) begin miscompares++; $display("FAIL stray_sweep_start got=%b exp=1", s_sweep_start); end
      s_pixels(S_PIX - 1, 1);
      repeat (3) tick();
      vectors++;
      if ({s_out_ch, s_in_ch, s_busy} !== {4'd0, 4'd0, 1'b1}) begin
         miscompares++; $display("FAIL stray_not_counted got pair=%0d,%0d busy=%b exp 0,0,1", s_out_ch, s_in_ch, s_busy);
      end
      s_pixels(1, 0);
      tick();
      vectors++;
      if ({s_wt_req, s_in_ch} !== {1'b1, 4'd1}) begin
         miscompares++; $display("FAIL sweep_end_full got req=%b in_ch=%0d exp 1,1", s_wt_req, s_in_ch);
      end
      s_buf = 1'b1;
      for (int p = 1; p < S_NI * S_NO; p++) begin
         s_wait_start(to);
         s_pixels(S_PIX, 0);
      end
      s_wait_done(to);
      vectors++;
      if ({to, s_err} !== 2'b01) begin miscompares++; $display("FAIL stray_sticky got to=%b err=%b exp 0,1", to, s_err); end
      tick();
      s_pulse_start();
      vectors++;
      if (s_err !== 1'b0) begin miscompares++; $display("FAIL stray_clear got=%b exp=0", s_err); end
      for (int p = 0; p < S_NI * S_NO; p++) begin
         s_wait_start(to);
         s_pixels(S_PIX, 0);
      end
      s_wait_done(to);
      tick();
   endtask

   task automatic test_busy_start();
      bit to;
      int st0 = s_starts, dn0 = s_dones;
      s_ack = 1'b1; s_buf = 1'b1;
      tick();
      s_pulse_start();
      s_wait_start(to);
      s_pixels(8, 0);
      s_pulse_start();
      s_pixels(S_PIX - 8, 0);
      s_wait_start(to);
      vectors++;
      if ({to, s_out_ch, s_in_ch} !== {1'b0, 4'd0, 4'd1}) begin
         miscompares++; $display("FAIL busy_start_ignored got to=%b pair=%0d,%0d exp 0,0,1", to, s_out_ch, s_in_ch);
      end
      s_pixels(S_PIX, 0);
      for (int p = 2; p < S_NI * S_NO; p++) begin
         s_wait_start(to);
         s_pixels(S_PIX, 0);
      end
      s_wait_done(to);
      s_pulse_start();
      vectors++;
      if ({s_busy, s_wt_req} !== 2'b00) begin
         miscompares++; $display("FAIL start_in_done_ignored got busy=%b req=%b exp 0,0", s_busy, s_wt_req);
      end
      repeat (3) tick();
      vectors++;
      if ((s_starts - st0) !== 4 || (s_dones - dn0) !== 1) begin
         miscompares++; $display("FAIL busy_counts starts=%0d dones=%0d exp 4,1", s_starts - st0, s_dones - dn0);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int st0, dn0;
      s_ack = 1'b1; s_buf = 1'b1;
      tick();
      s_pulse_start();
      for (int p = 0; p < 2; p++) begin
         s_wait_start(to);
         s_pixels(S_PIX, 0);
      end
      s_wait_start(to);
      vectors++;
      if ({s_out_ch, s_in_ch} !== {4'd1, 4'd0}) begin
         miscompares++; $display("FAIL mid_pair got=%0d,%0d exp 1,0", s_out_ch, s_in_ch);
      end
      s_pixels(7, 0);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (s_outs !== 15'd0) begin miscompares++; $display("FAIL reset_async got=%h exp=0", s_outs); end
      @(negedge clk) rst_n = 1'b1;
      tick();
      st0 = s_starts; dn0 = s_dones;
      s_pulse_start();
      for (int p = 0; p < S_NI * S_NO; p++) begin
         s_wait_start(to);
         vectors++;
         if ({to, s_out_ch, s_in_ch} !== {1'b0, 4'(p / S_NI), 4'(p % S_NI)}) begin
            miscompares++; $display("FAIL restart_pair p=%0d got to=%b %0d,%0d", p, to, s_out_ch, s_in_ch);
         end
         s_pixels(S_PIX, 1);
      end
      s_wait_done(to);
      tick();
      vectors++;
      if ((s_starts - st0) !== 4 || (s_dones - dn0) !== 1) begin
         miscompares++; $display("FAIL restart_counts starts=%0d dones=%0d exp 4,1", s_starts - st0, s_dones - dn0);
      end
   endtask

   task automatic test_gappy();
      bit to, early;
      int n;
      int st0 = d_starts, dn0 = d_dones;
      d_ack = 1'b1; d_buf = 1'b1;
      tick();
      d_start = 1'b1;
      tick();
      d_start = 1'b0;
      for (int p = 0; p < D_NI * D_NO; p++) begin
         n = 0; to = 1'b0;
         while (d_sweep_start !== 1'b1) begin
            tick(); n++;
            if (n > 20) begin to = 1'b1; break; end
         end
         vectors++;
         if ({to, d_out_ch, d_in_ch, d_acc_first, d_acc_last} !==
             {1'b0, 4'(p / D_NI), 4'(p % D_NI), (p % D_NI) == 0, (p % D_NI) == D_NI - 1}) begin
            miscompares++;
            $display("FAIL gappy_pair p=%0d got to=%b %0d,%0d f%b l%b", p, to, d_out_ch, d_in_ch, d_acc_first, d_acc_last);
         end
         early = 1'b0;
         for (int k = 0; k < D_PIX; k++) begin
            repeat ($urandom_range(0, 2)) begin
               tick();
               if (d_wt_req !== 1'b0 || d_sweep_start !== 1'b0 || d_busy !== 1'b1) early = 1'b1;
            end
            d_pixel = 1'b1;
            tick();
            d_pixel = 1'b0;
            if (k < D_PIX - 1 && (d_wt_req !== 1'b0 || d_sweep_start !== 1'b0)) early = 1'b1;
         end
         vectors++;
         if (early !== 1'b0) begin miscompares++; $display("FAIL pix_per_sweep p=%0d got early_end=1 exp 0", p); end
      end
      vectors++;
      if ({d_done, d_busy} !== 2'b01) begin
         miscompares++; $display("FAIL done_not_early got done=%b busy=%b exp 0,1", d_done, d_busy);
      end
      tick();
      vectors++;
      if (d_done !== 1'b1) begin miscompares++; $display("FAIL done_latency got=%b exp=1", d_done); end
      tick();
      vectors++;
      if ({d_done, d_busy} !== 2'b00) begin
         miscompares++; $display("FAIL gappy_idle got done=%b busy=%b exp 0,0", d_done, d_busy);
      end
      vectors++;
      if ((d_starts - st0) !== D_NI * D_NO || (d_dones - dn0) !== 1) begin
         miscompares++; $display("FAIL gappy_counts starts=%0d dones=%0d exp 12,1", d_starts - st0, d_dones - dn0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      s_start = 1'b0; s_ack = 1'b0; s_buf = 1'b0; s_pixel = 1'b0;
      d_start = 1'b0; d_ack = 1'b0; d_buf = 1'b0; d_pixel = 1'b0;
      test_reset();
      test_basic();
      test_delayed();
      test_stray();
      test_busy_start();
      test_reset_mid();
      test_gappy();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
